// File: rtl/mul_div_unit_pkg.sv
// rtl/mul_div_unit_pkg.sv - aluFunct codes shared by the HI/LO multiply/divide unit
package mul_div_unit_pkg;

    localparam logic [5:0] FUN_MFHI  = 6'b010000;
    localparam logic [5:0] FUN_MTHI  = 6'b010001;
    localparam logic [5:0] FUN_MFLO  = 6'b010010;
    localparam logic [5:0] FUN_MTLO  = 6'b010011;
    localparam logic [5:0] FUN_MULT  = 6'b011000;
    localparam logic [5:0] FUN_MULTU = 6'b011001;
    localparam logic [5:0] FUN_DIV   = 6'b011010;
    localparam logic [5:0] FUN_DIVU  = 6'b011011;

endpackage

// File: rtl/mul_div_unit_if.sv
// rtl/mul_div_unit_if.sv - request/result bundle between the EX stage and the HI/LO unit
interface mul_div_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [5:0]       funct;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (output start, funct, a, b, input busy, done, hi, lo);
    modport slave  (input start, funct, a, b, output busy, done, hi, lo);
endinterface

// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - iterative HI/LO multiply/divide, one bit per cycle
// Shift-add multiply and restoring divide on operand magnitudes; signs fixed up in FIX.
module mul_div_unit
    import mul_div_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic           clk,
    input  logic           rst,
    mul_div_unit_if.slave  bus
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [2*WIDTH-1:0] ONE2 = {{(2*WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    function automatic logic [2*WIDTH-1:0] twos(input logic [2*WIDTH-1:0] x);
        return ~x + ONE2;
    endfunction

    state_t             state;
    logic [CW-1:0]      cnt;
    logic               is_div;
    logic               neg_q;
    logic               neg_r;
    logic               div_zero;
    logic [WIDTH-1:0]   opnd;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic               done_q;

    logic               is_md;
    logic               op_signed;
    logic               sa;
    logic               sb;
    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH:0]     rem_sub;
    logic [2*WIDTH-1:0] acc_next;
    logic [WIDTH-1:0]   quot;
    logic [WIDTH-1:0]   rem;

    always_comb begin
        is_md     = (bus.funct == FUN_MULT) || (bus.funct == FUN_MULTU) ||
                    (bus.funct == FUN_DIV)  || (bus.funct == FUN_DIVU);
        op_signed = (bus.funct == FUN_MULT) || (bus.funct == FUN_DIV);
        sa        = op_signed & bus.a[WIDTH-1];
        sb        = op_signed & bus.b[WIDTH-1];
        abs_a     = sa ? WIDTH'(twos({{WIDTH{1'b0}}, bus.a})) : bus.a;
        abs_b     = sb ? WIDTH'(twos({{WIDTH{1'b0}}, bus.b})) : bus.b;
    end

    // acc holds the product for multiply and {remainder, quotient} for divide.
    always_comb begin
        mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
        rem_sh   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        rem_sub  = rem_sh - {1'b0, opnd};
        acc_next = {mul_sum, acc[WIDTH-1:1]};
        if (is_div) begin
            if (!rem_sub[WIDTH])
                acc_next = {rem_sub[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            else
                acc_next = {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        end
        quot = acc[WIDTH-1:0];
        rem  = acc[2*WIDTH-1:WIDTH];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            is_div   <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
            opnd     <= '0;
            acc      <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        if (is_md) begin
                            is_div   <= bus.funct[1];
                            opnd     <= bus.funct[1] ? abs_b : abs_a;
                            acc      <= {{WIDTH{1'b0}}, bus.funct[1] ? abs_a : abs_b};
                            neg_q    <= sa ^ sb;
                            neg_r    <= sa;
                            div_zero <= (bus.b == '0);
                            cnt      <= '0;
                            state    <= RUN;
                        end else if (bus.funct == FUN_MTHI) begin
                            hi_q <= bus.a;
                        end else if (bus.funct == FUN_MTLO) begin
                            lo_q <= bus.a;
                        end
                    end
                end
                RUN: begin
                    acc <= acc_next;
                    cnt <= cnt + CW'(1);
                    if (cnt == LAST)
                        state <= FIX;
                end
                FIX: begin
                    if (is_div) begin
                        // A zero divisor leaves |a| in rem, so rem's sign fix restores a.
                        lo_q <= div_zero ? {WIDTH{1'b1}}
                                         : (neg_q ? WIDTH'(twos({{WIDTH{1'b0}}, quot})) : quot);
                        hi_q <= neg_r ? WIDTH'(twos({{WIDTH{1'b0}}, rem})) : rem;
                    end else begin
                        {hi_q, lo_q} <= neg_q ? twos(acc) : acc;
                    end
                    done_q <= 1'b1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy = (state != IDLE);
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// tb/tb_mul_div_unit.sv - self-checking bench for mul_div_unit
module tb_mul_div_unit;
    import mul_div_unit_pkg::*;

    localparam int W = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    mul_div_unit_if #(.WIDTH(W)) bus ();

    mul_div_unit #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]   funct;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic model(input logic [5:0] f, input logic [W-1:0] x, input logic [W-1:0] y,
                         output logic [W-1:0] mh, output logic [W-1:0] ml);
        longint sp;
        longint unsigned up;
        int q, r;
        mh = '0;
        ml = '0;
        case (f)
            FUN_MULT: begin
                sp = longint'($signed(x)) * longint'($signed(y));
                {mh, ml} = sp;
            end
            FUN_MULTU: begin
                up = {32'b0, x} * {32'b0, y};
                {mh, ml} = up;
            end
            FUN_DIV: begin
                if (y == 0) begin
                    ml = '1; mh = x;
                end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
                    ml = 32'h8000_0000; mh = 0;
                end else begin
                    q = $signed(x) / $signed(y);
                    r = $signed(x) % $signed(y);
                    ml = q; mh = r;
                end
            end
            FUN_DIVU: begin
                if (y == 0) begin
                    ml = '1; mh = x;
                end else begin
                    ml = x / y; mh = x % y;
                end
            end
            default: ;
        endcase
    endtask

    task automatic start_op(input logic [5:0] f, input logic [W-1:0] x, input logic [W-1:0] y);
        int g = 0;
        while (bus.busy && g < 200) begin
            @(negedge clk);
            g++;
        end
        if (bus.busy) chk("idle_timeout", 1, 0);
        bus.start = 1'b1;
        bus.funct = f;
        bus.a     = x;
        bus.b     = y;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input logic [W-1:0] h0, input logic [W-1:0] l0,
                             output int lat, output int busy_n, output bit held);
        lat    = 1;
        busy_n = 0;
        held   = 1'b1;
        while (!bus.done && lat < 100) begin
            if (bus.busy) busy_n++;
            if (bus.hi !== h0 || bus.lo !== l0) held = 1'b0;
            @(negedge clk);
            lat++;
        end
        if (!bus.done) chk("done_timeout", 1, 0);
    endtask

    task automatic do_op(input string name, input logic [5:0] f, input logic [W-1:0] x,
                         input logic [W-1:0] y, input logic [W-1:0] eh, input logic [W-1:0] el);
        logic [W-1:0] h0, l0;
        int lat, bn;
        bit held;
        h0 = bus.hi;
        l0 = bus.lo;
        start_op(f, x, y);
        wait_done(h0, l0, lat, bn, held);
        chk({name, "_latency"}, lat, W + 2);
        chk({name, "_busy_cycles"}, bn, W + 1);
        chk({name, "_hold"}, held, 1);
        chk({name, "_busy_in_done"}, bus.busy, 0);
        chk({name, "_hi"}, bus.hi, eh);
        chk({name, "_lo"}, bus.lo, el);
    endtask

    initial begin
        logic [W-1:0] x, y, mh, ml;
        logic [5:0]   f;
        int lat, bn;
        bit held;

        vecs[0] = '{FUN_MULT,  32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
        vecs[1] = '{FUN_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
        vecs[2] = '{FUN_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[3] = '{FUN_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
        vecs[4] = '{FUN_DIVU,  32'h0000_0007, 32'h0000_0000, 32'h0000_0007, 32'hFFFF_FFFF};
        vecs[5] = '{FUN_DIV,   32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF};
        vecs[6] = '{FUN_DIVU,  32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E};
        vecs[7] = '{FUN_DIV,   32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
        vecs[8] = '{FUN_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
        vecs[9] = '{FUN_MULTU, 32'h0000_0000, 32'h0001_2345, 32'h0000_0000, 32'h0000_0000};

        bus.start = 1'b0;
        bus.funct = '0;
        bus.a     = '0;
        bus.b     = '0;
        repeat (3) @(negedge clk);
        chk("reset_busy", bus.busy, 0);
        chk("reset_done", bus.done, 0);
        chk("reset_hi", bus.hi, 0);
        chk("reset_lo", bus.lo, 0);
        rst = 1'b0;
        @(negedge clk);

        // Consecutive table entries start in the previous op's done cycle.
        for (int i = 0; i < 10; i++)
            do_op($sformatf("vec%0d", i), vecs[i].funct, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo);

        @(negedge clk);
        chk("done_pulse_width", bus.done, 0);

        start_op(FUN_MTLO, 32'h0000_1234, 32'h0);
        chk("mtlo_lo", bus.lo, 32'h0000_1234);
        chk("mtlo_busy", bus.busy, 0);
        chk("mtlo_done", bus.done, 0);
        start_op(FUN_MTHI, 32'h0000_BEEF, 32'h0);
        chk("mthi_hi", bus.hi, 32'h0000_BEEF);
        start_op(FUN_MFHI, 32'h5555_5555, 32'h0);
        chk("ignored_hi", bus.hi, 32'h0000_BEEF);
        chk("ignored_lo", bus.lo, 32'h0000_1234);
        chk("ignored_busy", bus.busy, 0);

        start_op(FUN_MULT, 32'd3, 32'd4);
        repeat (3) @(negedge clk);
        bus.start = 1'b1;
        bus.funct = FUN_MTHI;
        bus.a     = 32'h0000_DEAD;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(32'h0000_BEEF, 32'h0000_1234, lat, bn, held);
        chk("mthi_busy_hold", held, 1);
        chk("mthi_busy_hi", bus.hi, 0);
        chk("mthi_busy_lo", bus.lo, 32'd12);

        do_op("pre_rst", FUN_MULTU, 32'd7, 32'd9, 32'd0, 32'd63);
        start_op(FUN_MULT, 32'd5, 32'd6);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_busy", bus.busy, 0);
        chk("midrst_hi", bus.hi, 0);
        chk("midrst_lo", bus.lo, 0);
        chk("midrst_done", bus.done, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        do_op("post_rst", FUN_MULTU, 32'd3, 32'd5, 32'd0, 32'h0000_000F);

        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 3))
                0: f = FUN_MULT;
                1: f = FUN_MULTU;
                2: f = FUN_DIV;
                default: f = FUN_DIVU;
            endcase
            x = $urandom();
            y = $urandom();
            case ($urandom_range(0, 7))
                0: y = 0;
                1: y = 32'hFFFF_FFFF;
                2: x = 32'h8000_0000;
                3: y = $urandom_range(1, 15);
                default: ;
            endcase
            model(f, x, y, mh, ml);
            do_op($sformatf("rand%0d_f%0h_a%h_b%h", i, f, x, y), f, x, y, mh, ml);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
